// File: rtl/popcount18_unary_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : popcount_pkg
// Description : Shared constants and types for the popcount18 unary
//               transmitter: frame length, count width, FSM state type and
//               the count word type.
// Revision    : 1.0 - initial release
// ============================================================================
package popcount_pkg;

    localparam int POPCOUNT_N  = 18;
    localparam int POPCOUNT_CW = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    typedef logic [POPCOUNT_CW-1:0] count_t;

endpackage
`default_nettype wire

// File: rtl/popcount18_unary_tx_bit_sel.sv
`default_nettype none
// ============================================================================
// Module      : popcount_bit_sel
// Description : Combinational bit selector for one beat of a unary frame.
//               Thermometer build : bit = (idx < cnt).
//               Spread build      : bit = (acc + cnt >= N)  (Bresenham).
//               The spread pattern is selected by POPCOUNT_TX_SPREAD_EN.
// Ports       : i_idx  beat index within the frame
//               i_cnt  clamped ones count of the frame
//               i_acc  Bresenham accumulator for this beat
//               o_bit  serial bit for this beat
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_bit_sel
    import popcount_pkg::*;
#(
    parameter int N  = POPCOUNT_N,
    parameter int CW = POPCOUNT_CW
) (
    input  logic [CW-1:0] i_idx,
    input  logic [CW-1:0] i_cnt,
    input  logic [CW:0]   i_acc,
    output logic          o_bit
);

`ifdef POPCOUNT_TX_SPREAD_EN
    logic [CW:0] w_t;
    logic        w_unused_idx;

    // acc < N and cnt <= N, so the sum never exceeds CW+1 bits.
    assign w_t          = i_acc + {1'b0, i_cnt};
    assign o_bit        = (w_t >= (CW+1)'(N));
    assign w_unused_idx = ^i_idx;
`else
    logic w_unused_acc;

    assign o_bit        = (i_idx < i_cnt);
    assign w_unused_acc = ^i_acc;
`endif

endmodule
`default_nettype wire

// File: rtl/popcount18_unary_tx.sv
`default_nettype none
// ============================================================================
// Module      : popcount18_unary_tx
// Description : Accepts a count (0..N, larger values clamped to N) and emits
//               it as an N-beat unary bit frame holding exactly that many
//               ones. Valid/ready handshake on both sides; zero-bubble
//               frame chaining when a new count arrives on the last beat.
//               Define POPCOUNT_TX_SPREAD_EN to spread the ones evenly
//               (Bresenham) instead of the default thermometer pattern.
// Ports       : clk, rst        clock, synchronous active-high reset
//               in_valid/ready  count handshake, in_count requested ones
//               out_valid/ready beat handshake
//               out_bit         serial bit; out_first/out_last frame marks
//               clamped         one-cycle pulse when in_count exceeded N
// Revision    : 1.0 - initial release
// ============================================================================
module popcount18_unary_tx
    import popcount_pkg::*;
#(
    parameter int N  = POPCOUNT_N,
    parameter int CW = POPCOUNT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bit,
    output logic          out_first,
    output logic          out_last,
    output logic          clamped
);

    localparam logic [CW-1:0] c_N    = CW'(N);
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    state_t        r_state;
    logic [CW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_bit;
    logic          r_first;
    logic          r_last;
    logic          r_clamped;

    logic          w_accept;
    logic          w_beat;
    logic          w_end;
    logic          w_over;
    logic [CW-1:0] w_cnt_new;
    logic [CW-1:0] w_idx_inc;
    logic [CW-1:0] w_sel_idx;
    logic [CW-1:0] w_sel_cnt;
    logic [CW:0]   w_sel_acc;
    logic          w_sel_bit;

    // Ready in IDLE, or on the last beat of a frame that is being accepted,
    // so a new count can be chained without a bubble.
    assign in_ready  = (r_state == ST_IDLE) |
                       ((r_state == ST_SEND) & (r_idx == c_LAST) & out_ready);
    assign out_valid = (r_state == ST_SEND);
    assign out_bit   = r_bit;
    assign out_first = r_first;
    assign out_last  = r_last;
    assign clamped   = r_clamped;

    assign w_accept  = in_valid & in_ready;
    assign w_beat    = out_valid & out_ready;
    assign w_end     = w_beat & (r_idx == c_LAST);
    assign w_over    = (in_count > c_N);
    assign w_cnt_new = w_over ? c_N : in_count;
    assign w_idx_inc = r_idx + 1'b1;

`ifdef POPCOUNT_TX_SPREAD_EN
    logic [CW:0] r_acc;
    logic [CW:0] w_acc_t;
    logic [CW:0] w_acc_nxt;

    // Accumulator for the beat following the one currently presented.
    assign w_acc_t   = r_acc + {1'b0, r_cnt};
    assign w_acc_nxt = r_bit ? (w_acc_t - (CW+1)'(N)) : w_acc_t;
    assign w_sel_acc = w_accept ? '0 : w_acc_nxt;
`else
    assign w_sel_acc = '0;
`endif

    // Bit selection looks one beat ahead so out_bit can be registered.
    assign w_sel_idx = w_accept ? '0 : w_idx_inc;
    assign w_sel_cnt = w_accept ? w_cnt_new : r_cnt;

    popcount_bit_sel #(
        .N  (N),
        .CW (CW)
    ) u_bit_sel (
        .i_idx (w_sel_idx),
        .i_cnt (w_sel_cnt),
        .i_acc (w_sel_acc),
        .o_bit (w_sel_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_bit     <= 1'b0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_clamped <= 1'b0;
`ifdef POPCOUNT_TX_SPREAD_EN
            r_acc     <= '0;
`endif
        end else begin
            r_clamped <= w_accept & w_over;
            if (w_accept) begin
                r_state <= ST_SEND;
                r_idx   <= '0;
                r_cnt   <= w_cnt_new;
                r_bit   <= w_sel_bit;
                r_first <= 1'b1;
                r_last  <= 1'b0;
`ifdef POPCOUNT_TX_SPREAD_EN
                r_acc   <= '0;
`endif
            end else if (w_end) begin
                r_state <= ST_IDLE;
                r_idx   <= '0;
                r_bit   <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_beat) begin
                r_idx   <= w_idx_inc;
                r_bit   <= w_sel_bit;
                r_first <= 1'b0;
                r_last  <= (w_idx_inc == c_LAST);
`ifdef POPCOUNT_TX_SPREAD_EN
                r_acc   <= w_acc_nxt;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/popcount18_unary_tx.md
Name: popcount18_unary_tx

Overview:
- Inverse of the popcount18 family: accepts a 5-bit count (0..18) and serialises it as an 18-beat unary bit frame containing exactly that many ones.
- Used as a stimulus source for popcount18 characterisation benches.
- Used as a serial activation driver where the ternary neuron's sensor side consumes one bit per cycle.
- Valid/ready handshake on both the count input and the bit output.

Parameters:
- N, 18, frame length in beats (bits per frame); max legal count.
- CW, 5, count width; must satisfy 2^CW > N.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  count word valid.
- in_ready  output  1  block can accept a count this cycle.
- in_count  input  CW  requested number of ones in the frame.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts the current beat.
- out_bit  output  1  current serial bit.
- out_first  output  1  current beat is beat 0 of the frame.
- out_last  output  1  current beat is beat N-1 of the frame.
- clamped  output  1  one-cycle pulse when an accepted in_count exceeded N.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - state=IDLE; in_ready=1; out_valid=0; out_bit=0; out_first=0; out_last=0; clamped=0.
  - Internal beat index, ones counter and accumulator cleared.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - SEND: out_valid=1.
- Acceptance: in_valid & in_ready at an edge.
  - Latch cnt = min(in_count, N).
  - Pulse clamped for exactly the next cycle iff in_count > N.
  - Go to SEND with beat index 0.
- Latency: first beat presented on out_* the cycle after acceptance. All out_* are registered.
- Beat advance: only on out_valid & out_ready. When out_ready=0, out_bit, out_first and out_last hold stable; index does not move.
- out_first=1 when index=0; out_last=1 when index=N-1.
- Default pattern is thermometer: out_bit = (index < cnt), i.e. cnt ones followed by N-cnt zeros.
- Frame end, on the accepted last beat:
  - If in_valid also accepted that edge: reload and start the next frame with zero bubble. in_ready is combinationally high in SEND when index=N-1 & out_ready.
  - Otherwise return to IDLE; out_valid=0 next cycle.
- in_ready=0 at all other SEND cycles; in_count is ignored there.
- Boundary counts:
  - cnt=0: N zeros, out_valid still asserted for N beats.
  - cnt=N: N ones.
  - Frame is always exactly N accepted beats.
- Reset mid-frame: frame is aborted immediately; no partial-frame completion; out_valid=0 the cycle after rst.
- Invariant checked by bench: sum of out_bit over accepted beats of a frame == clamped cnt.

Optional Feature:
- Macro: POPCOUNT_TX_SPREAD_EN.
- When defined, ones are distributed evenly (Bresenham) instead of thermometer:
  - Accumulator acc (width CW+1) starts at 0 on acceptance.
  - On each beat, t = acc + cnt.
  - out_bit = (t >= N).
  - On beat acceptance, acc <= t - (out_bit ? N : 0).
  - The frame still carries exactly cnt ones.
  - Example: cnt=9, N=18 gives 0101...01.
- When not defined, the accumulator logic is absent and the thermometer pattern is used.
- Handshake, latency and flags are identical in both builds.

Decomposition:
- Shared package popcount_pkg holds:
  - Constants POPCOUNT_N=18 and POPCOUNT_CW=5.
  - An enum type for the IDLE/SEND state.
  - A typedef for the count word.
- One natural sub-module: popcount_bit_sel. It is combinational and returns the bit for (index, cnt, acc), selecting thermometer or spread under the macro, so the bench can reuse it as a reference model.

Test Plan:
- Reset then in_count=7 with out_ready=1 -> out_valid rises 1 cycle later; bits 1111111 then 11 zeros; out_first on beat 0; out_last on beat 17; ones sum=7.
- Back-to-back counts 18 then 0 with in_valid held -> 36 consecutive valid beats, no bubble; 18 ones then 18 zeros; in_ready high only on beat 17.
- in_count=25 -> clamped pulses one cycle; frame of 18 ones.
- in_count=5 with out_ready toggling 1,0,0,1 pseudo-randomly -> outputs stable while stalled; exactly 18 accepted beats; 5 ones.
- rst asserted at beat 9 of a cnt=12 frame -> out_valid=0 next cycle; in_ready=1; a new in_count=3 is then sent correctly.
- With POPCOUNT_TX_SPREAD_EN, cnt=6 -> pattern 001001001001001001; cnt=0 and cnt=18 give all-zero and all-one frames.
